step_pulse_generator: RTL and testbench
=======================================

Name: step_pulse_generator

Overview:
- Consumes the motion-profile parameter set produced by the speed-to-timing stage (N, nn, t0, tna, delta) and emits the physical STEP/DIR pulse train for one axis.
- Per step, the step period ramps from t0 down to tna by delta every nn steps, cruises, then decelerates symmetrically back toward t0 over the final steps.
- Sits between the speed-to-timing stage and the stepper driver pins; one instance per axis.

Parameters:
- PULSE_W, 4, STEP high time in clk cycles.
- CNT_W, 32, width of all period, step and group counters.

Ports:
- clk  in  1  system clock (MAIN_FREQ)
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin the move; sampled only in IDLE when params_valid=1
- abort  in  1  synchronous stop request
- params_valid  in  1  upstream finish flag; the parameter inputs are stable while it is high
- dir_in  in  1  move direction (sign of the original num)
- n_steps  in  32  N, total microsteps (unsigned)
- nn  in  32  steps per ramp group
- t0  in  32  start/stop period, clk cycles
- tna  in  32  cruise period, clk cycles
- delta  in  32  period change per group
- step  out  1  STEP pulse
- dir_out  out  1  latched direction
- busy  out  1  high from LOAD through the last step end
- done  out  1  one-cycle pulse at move completion
- step_count  out  32  steps completed in the current move

Behaviour:
- Reset values (asynchronous, reset=0): step=0, dir_out=0, busy=0, done=0, step_count=0, state=IDLE, all internal registers cleared.
- States: IDLE, LOAD, ACCEL, CRUISE, DECEL, FINISH.
- IDLE, start&params_valid at cycle c: latch all five parameters and dir_in. dir_out updates at c+1.
- LOAD, cycle c+1:
  - busy=1; k=0, g=0, cur=t0, a_steps=0.
  - If N==0, go to FINISH.
  - Else if nn==0, delta==0 or t0<=tna, go to CRUISE with cur=t0 for every step (constant-speed move).
  - Otherwise go to ACCEL.
- Step timing:
  - The first step rises at cycle c+2.
  - Timer tc runs 0..P-1, with P=max(cur, 2*PULSE_W).
  - step=1 while tc<PULSE_W.
  - At tc==P-1 the step ends: k++, step_count++, and the phase rules below are evaluated. The next step begins at tc=0 on the following cycle.
- ACCEL step end:
  1. g++.
  2. If g==nn: g=0 and cur=(cur>tna+delta)?cur-delta:tna.
  3. If 2k>=N, enter DECEL with a_steps=k (takes priority over rule 4).
  4. Else if cur==tna, enter CRUISE with a_steps=k.
- CRUISE step end: if a_steps!=0 and N-k<=a_steps, enter DECEL.
- DECEL entry (mirror of the ramp):
  - g=nn-g_old (g_old = 0 when entering from CRUISE).
  - If g==nn, set g=0 and cur=min(cur+delta, t0) immediately.
- DECEL step end: g++. If g==nn: g=0, cur=min(cur+delta, t0).
- Completion:
  - Whichever step end makes k==N goes to FINISH, regardless of phase.
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
  - step_count holds its value until the next LOAD.
- abort:
  - Any active state: step forced low at once, go to FINISH, done pulses.
  - In IDLE, abort is ignored.
- start while busy: ignored. Parameter input changes while busy: ignored (latched copy is used).
- Arithmetic: all unsigned, CNT_W bits. The tna+delta comparison uses CNT_W+1 bits to avoid wrap. cur never leaves [tna, t0].
- Reset asserted mid-move: step drops low asynchronously and the FSM returns to IDLE.

Decomposition:
- Shared package `motion_pkg`:
  - state enum
  - parameter index constants (N=0, NN=1, T0=2, TNA=3, DELTA=4) matching the upstream param ordering
  - CNT_W
- Sub-module `step_period_timer`: loadable down/up counter that takes P and PULSE_W and outputs step_level and period_end.

Test Plan:
- N=10, nn=2, t0=100, tna=60, delta=20, PULSE_W=4:
  - Periods are 100,100,80,80,60,60,80,80,100,100.
  - Each step is high for exactly 4 cycles.
  - done asserts 1 cycle after the 10th period ends; step_count=10.
- N=6, same ramp: periods 100,100,80,80,100,100 (triangle profile, DECEL entered from ACCEL mid-group).
- Constant speed, N=5, nn=0, t0=tna=50, delta=0: five 50-cycle periods; first rising step edge 2 cycles after start.
- N=0 with start: no step pulses; done pulses 2 cycles after start; busy high for 1 cycle.
- Abort asserted during step 4 of the first case: step low on the next cycle, done pulses, step_count=3. A subsequent start runs a full new move.
- Async reset (reset=0) mid-CRUISE: outputs clear without a clock edge. Release plus start with t0=3, PULSE_W=4 gives a period clamped to 8 cycles.

Source files
------------

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared state, widths and parameter indices for the axis motion path
package motion_pkg;

  localparam int CNT_W      = 32;
  localparam int NUM_PARAMS = 5;

  // Order matches the parameter set emitted by the speed-to-timing stage.
  localparam int IDX_N     = 0;
  localparam int IDX_NN    = 1;
  localparam int IDX_T0    = 2;
  localparam int IDX_TNA   = 3;
  localparam int IDX_DELTA = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACCEL,
    CRUISE,
    DECEL,
    FINISH
  } motion_state_t;

endpackage

// File: rtl/step_period_timer.sv
// rtl/step_period_timer.sv - per-step period counter producing the STEP level and period end
module step_period_timer #(
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic             step_level,
  output logic             period_end
);

  logic [CNT_W-1:0] tc;

  assign period_end = run && (tc == period - CNT_W'(1));
  assign step_level = run && (tc < CNT_W'(PULSE_W));

  // Holding tc at zero while idle means the next step always starts from a clean period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc <= '0;
    end else if (!run || period_end) begin
      tc <= '0;
    end else begin
      tc <= tc + CNT_W'(1);
    end
  end

endmodule

// File: rtl/step_pulse_generator.sv
// rtl/step_pulse_generator.sv - one-axis STEP/DIR pulse train with trapezoidal period ramp
module step_pulse_generator #(
  parameter int PULSE_W = 4,
  parameter int CNT_W   = motion_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             params_valid,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] n_steps,
  input  logic [CNT_W-1:0] nn,
  input  logic [CNT_W-1:0] t0,
  input  logic [CNT_W-1:0] tna,
  input  logic [CNT_W-1:0] delta,
  output logic             step,
  output logic             dir_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_count
);
  import motion_pkg::*;

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(2 * PULSE_W);

  motion_state_t    state;
  logic [CNT_W-1:0] prm [NUM_PARAMS];
  logic [CNT_W-1:0] g;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] a_steps;

  logic             run;
  logic             period_end;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] k_inc;
  logic [CNT_W-1:0] g_inc;

  motion_state_t    se_state;
  logic [CNT_W-1:0] se_g;
  logic [CNT_W-1:0] se_cur;
  logic [CNT_W-1:0] se_a;
  logic             enter_decel;

  function automatic logic [CNT_W-1:0] ramp_down(input logic [CNT_W-1:0] c,
                                                 input logic [CNT_W-1:0] lo,
                                                 input logic [CNT_W-1:0] d);
    return ({1'b0, c} > ({1'b0, lo} + {1'b0, d})) ? c - d : lo;
  endfunction

  function automatic logic [CNT_W-1:0] ramp_up(input logic [CNT_W-1:0] c,
                                               input logic [CNT_W-1:0] hi,
                                               input logic [CNT_W-1:0] d);
    logic [CNT_W:0] s;
    s = {1'b0, c} + {1'b0, d};
    return (s < {1'b0, hi}) ? s[CNT_W-1:0] : hi;
  endfunction

  assign run    = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
  assign period = (cur > MIN_P) ? cur : MIN_P;
  assign k_inc  = step_count + CNT_W'(1);
  assign g_inc  = g + CNT_W'(1);

  step_period_timer #(
    .PULSE_W (PULSE_W),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .period     (period),
    .step_level (step),
    .period_end (period_end)
  );

  // Phase bookkeeping applied at the end of the current step.
  always_comb begin
    se_state    = state;
    se_g        = g;
    se_cur      = cur;
    se_a        = a_steps;
    enter_decel = 1'b0;
    case (state)
      ACCEL: begin
        se_g = g_inc;
        if (g_inc == prm[IDX_NN]) begin
          se_g   = '0;
          se_cur = ramp_down(cur, prm[IDX_TNA], prm[IDX_DELTA]);
        end
        if ({k_inc, 1'b0} >= {1'b0, prm[IDX_N]}) begin
          enter_decel = 1'b1;
          se_a        = k_inc;
        end else if (se_cur == prm[IDX_TNA]) begin
          se_state = CRUISE;
          se_a     = k_inc;
        end
      end
      CRUISE: begin
        if ((a_steps != '0) && ((prm[IDX_N] - k_inc) <= a_steps)) begin
          enter_decel = 1'b1;
          se_g        = '0;
        end
      end
      DECEL: begin
        se_g = g_inc;
        if (g_inc == prm[IDX_NN]) begin
          se_g   = '0;
          se_cur = ramp_up(cur, prm[IDX_T0], prm[IDX_DELTA]);
        end
      end
      default: begin
      end
    endcase
    // Deceleration replays the ramp backwards, so the group position is mirrored.
    if (enter_decel) begin
      se_state = DECEL;
      se_g     = prm[IDX_NN] - se_g;
      if (se_g == prm[IDX_NN]) begin
        se_g   = '0;
        se_cur = ramp_up(se_cur, prm[IDX_T0], prm[IDX_DELTA]);
      end
    end
    if (k_inc == prm[IDX_N]) begin
      se_state = FINISH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      for (int i = 0; i < NUM_PARAMS; i++) begin
        prm[i] <= '0;
      end
      g          <= '0;
      cur        <= '0;
      a_steps    <= '0;
      dir_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_count <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE) && (state != FINISH)) begin
        state <= FINISH;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start && params_valid) begin
              prm[IDX_N]     <= n_steps;
              prm[IDX_NN]    <= nn;
              prm[IDX_T0]    <= t0;
              prm[IDX_TNA]   <= tna;
              prm[IDX_DELTA] <= delta;
              dir_out        <= dir_in;
              busy           <= 1'b1;
              state          <= LOAD;
            end
          end
          LOAD: begin
            step_count <= '0;
            g          <= '0;
            cur        <= prm[IDX_T0];
            a_steps    <= '0;
            if (prm[IDX_N] == '0) begin
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if ((prm[IDX_NN] == '0) || (prm[IDX_DELTA] == '0) ||
                         (prm[IDX_T0] <= prm[IDX_TNA])) begin
              state <= CRUISE;
            end else begin
              state <= ACCEL;
            end
          end
          ACCEL, CRUISE, DECEL: begin
            if (period_end) begin
              step_count <= k_inc;
              g          <= se_g;
              cur        <= se_cur;
              a_steps    <= se_a;
              state      <= se_state;
              if (se_state == FINISH) begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_generator.sv
// tb/tb_step_pulse_generator.sv - directed self-checking bench for step_pulse_generator
module tb_step_pulse_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        params_valid = 1'b0;
  logic        dir_in = 1'b0;
  logic [31:0] n_steps = '0;
  logic [31:0] nn = '0;
  logic [31:0] t0 = '0;
  logic [31:0] tna = '0;
  logic [31:0] delta = '0;
  logic        step;
  logic        dir_out;
  logic        busy;
  logic        done;
  logic [31:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;
  int rises[$];
  int highs[$];
  int done_at;
  int busy_cycles;

  always #5 clk = ~clk;

  step_pulse_generator #(
    .PULSE_W (4),
    .CNT_W   (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .params_valid (params_valid),
    .dir_in       (dir_in),
    .n_steps      (n_steps),
    .nn           (nn),
    .t0           (t0),
    .tna          (tna),
    .delta        (delta),
    .step         (step),
    .dir_out      (dir_out),
    .busy         (busy),
    .done         (done),
    .step_count   (step_count)
  );

  task automatic set_params(input int n, input int g, input int a, input int b, input int d);
    n_steps = n;
    nn      = g;
    t0      = a;
    tna     = b;
    delta   = d;
  endtask

  // Returns at the negedge one cycle after start was sampled (index 1 = LOAD cycle).
  task automatic start_move(input logic d);
    @(negedge clk);
    dir_in       = d;
    params_valid = 1'b1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect(input int budget);
    logic prev;
    int   hi;
    rises.delete();
    highs.delete();
    done_at     = -1;
    busy_cycles = 0;
    prev        = 1'b0;
    hi          = 0;
    for (int i = 1; i <= budget; i++) begin
      if (step && !prev) rises.push_back(i);
      if (step) hi++;
      else if (prev) begin
        highs.push_back(hi);
        hi = 0;
      end
      if (busy) busy_cycles++;
      prev = step;
      if (done) begin
        done_at = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic int period_of(input int j);
    if (j >= rises.size()) return -1;
    return (j + 1 < rises.size()) ? rises[j+1] - rises[j] : done_at - rises[j];
  endfunction

  function automatic int high_of(input int j);
    return (j < highs.size()) ? highs[j] : -1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({step, dir_out, busy, done} !== 4'b0000) begin n_bad++; $display("FAIL reset_outputs: got %b expected 0000", {step, dir_out, busy, done}); end
    n_cmp++; if (step_count !== 32'd0) begin n_bad++; $display("FAIL reset_step_count: got %0d expected 0", step_count); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({step, busy, done} !== 3'b000) begin n_bad++; $display("FAIL idle_outputs: got %b expected 000", {step, busy, done}); end
  endtask

  task automatic test_ramp();
    int exp_p[10] = '{100, 100, 80, 80, 60, 60, 80, 80, 100, 100};
    set_params(10, 2, 100, 60, 20);
    start_move(1'b1);
    n_cmp++; if (dir_out !== 1'b1) begin n_bad++; $display("FAIL ramp_dir_out: got %b expected 1", dir_out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ramp_busy_load: got %b expected 1", busy); end
    collect(2000);
    n_cmp++; if (rises.size() !== 10) begin n_bad++; $display("FAIL ramp_step_count_pulses: got %0d expected 10", rises.size()); end
    n_cmp++; if ((rises.size() > 0 ? rises[0] : -1) !== 2) begin n_bad++; $display("FAIL ramp_first_rise: got %0d expected 2", rises.size() > 0 ? rises[0] : -1); end
    for (int j = 0; j < 10; j++) begin
      n_cmp++; if (period_of(j) !== exp_p[j]) begin n_bad++; $display("FAIL ramp_period[%0d]: got %0d expected %0d", j, period_of(j), exp_p[j]); end
      n_cmp++; if (high_of(j) !== 4) begin n_bad++; $display("FAIL ramp_high[%0d]: got %0d expected 4", j, high_of(j)); end
    end
    n_cmp++; if (done_at !== 842) begin n_bad++; $display("FAIL ramp_done_at: got %0d expected 842", done_at); end
    n_cmp++; if (busy_cycles !== 841) begin n_bad++; $display("FAIL ramp_busy_cycles: got %0d expected 841", busy_cycles); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ramp_done_width: got %b expected 0", done); end
    n_cmp++; if (step_count !== 32'd10) begin n_bad++; $display("FAIL ramp_final_count: got %0d expected 10", step_count); end
  endtask

  task automatic test_triangle();
    int exp_p[6] = '{100, 100, 80, 80, 100, 100};
    set_params(6, 2, 100, 60, 20);
    start_move(1'b0);
    n_cmp++; if (dir_out !== 1'b0) begin n_bad++; $display("FAIL tri_dir_out: got %b expected 0", dir_out); end
    collect(2000);
    n_cmp++; if (rises.size() !== 6) begin n_bad++; $display("FAIL tri_pulses: got %0d expected 6", rises.size()); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++; if (period_of(j) !== exp_p[j]) begin n_bad++; $display("FAIL tri_period[%0d]: got %0d expected %0d", j, period_of(j), exp_p[j]); end
    end
    n_cmp++; if (done_at !== 562) begin n_bad++; $display("FAIL tri_done_at: got %0d expected 562", done_at); end
    @(negedge clk);
    n_cmp++; if (step_count !== 32'd6) begin n_bad++; $display("FAIL tri_final_count: got %0d expected 6", step_count); end
  endtask

  task automatic test_constant();
    set_params(5, 0, 50, 50, 0);
    start_move(1'b1);
    collect(1000);
    n_cmp++; if (rises.size() !== 5) begin n_bad++; $display("FAIL const_pulses: got %0d expected 5", rises.size()); end
    n_cmp++; if ((rises.size() > 0 ? rises[0] : -1) !== 2) begin n_bad++; $display("FAIL const_first_rise: got %0d expected 2", rises.size() > 0 ? rises[0] : -1); end
    for (int j = 0; j < 5; j++) begin
      n_cmp++; if (period_of(j) !== 50) begin n_bad++; $display("FAIL const_period[%0d]: got %0d expected 50", j, period_of(j)); end
    end
    n_cmp++; if (done_at !== 252) begin n_bad++; $display("FAIL const_done_at: got %0d expected 252", done_at); end
  endtask

  task automatic test_zero_steps();
    set_params(0, 2, 100, 60, 20);
    start_move(1'b0);
    collect(50);
    n_cmp++; if (rises.size() !== 0) begin n_bad++; $display("FAIL zero_pulses: got %0d expected 0", rises.size()); end
    n_cmp++; if (done_at !== 2) begin n_bad++; $display("FAIL zero_done_at: got %0d expected 2", done_at); end
    n_cmp++; if (busy_cycles !== 1) begin n_bad++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cycles); end
    n_cmp++; if (step_count !== 32'd0) begin n_bad++; $display("FAIL zero_step_count: got %0d expected 0", step_count); end
  endtask

  task automatic test_abort();
    logic prev;
    int   nr;
    int   rise4;
    set_params(10, 2, 100, 60, 20);
    start_move(1'b1);
    prev  = 1'b0;
    nr    = 0;
    rise4 = -1;
    for (int i = 1; i < 2000; i++) begin
      if (step && !prev) begin
        nr++;
        if (nr == 4) rise4 = i;
      end
      prev = step;
      if (nr == 4) break;
      @(negedge clk);
    end
    n_cmp++; if (rise4 !== 282) begin n_bad++; $display("FAIL abort_rise4: got %0d expected 282", rise4); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL abort_step_low: got %b expected 0", step); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL abort_done: got %b expected 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (step_count !== 32'd3) begin n_bad++; $display("FAIL abort_step_count: got %0d expected 3", step_count); end
    start_move(1'b0);
    collect(2000);
    n_cmp++; if (rises.size() !== 10) begin n_bad++; $display("FAIL restart_pulses: got %0d expected 10", rises.size()); end
    n_cmp++; if (done_at !== 842) begin n_bad++; $display("FAIL restart_done_at: got %0d expected 842", done_at); end
    @(negedge clk);
    n_cmp++; if (step_count !== 32'd10) begin n_bad++; $display("FAIL restart_count: got %0d expected 10", step_count); end
  endtask

  task automatic test_async_reset();
    logic prev;
    int   nr;
    set_params(5, 0, 50, 50, 0);
    start_move(1'b1);
    prev = 1'b0;
    nr   = 0;
    for (int i = 1; i < 500; i++) begin
      if (step && !prev) nr++;
      prev = step;
      if (nr == 2) break;
      @(negedge clk);
    end
    n_cmp++; if ({step, busy, dir_out} !== 3'b111) begin n_bad++; $display("FAIL arst_pre: got %b expected 111", {step, busy, dir_out}); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({step, busy, dir_out, done} !== 4'b0000) begin n_bad++; $display("FAIL arst_outputs: got %b expected 0000", {step, busy, dir_out, done}); end
    n_cmp++; if (step_count !== 32'd0) begin n_bad++; $display("FAIL arst_step_count: got %0d expected 0", step_count); end
    @(negedge clk);
    reset = 1'b1;
    set_params(3, 0, 3, 3, 0);
    start_move(1'b0);
    collect(200);
    n_cmp++; if (rises.size() !== 3) begin n_bad++; $display("FAIL clamp_pulses: got %0d expected 3", rises.size()); end
    for (int j = 0; j < 3; j++) begin
      n_cmp++; if (period_of(j) !== 8) begin n_bad++; $display("FAIL clamp_period[%0d]: got %0d expected 8", j, period_of(j)); end
      n_cmp++; if (high_of(j) !== 4) begin n_bad++; $display("FAIL clamp_high[%0d]: got %0d expected 4", j, high_of(j)); end
    end
    n_cmp++; if (done_at !== 26) begin n_bad++; $display("FAIL clamp_done_at: got %0d expected 26", done_at); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_triangle();
    test_constant();
    test_zero_steps();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
